// File: rtl/scic_mem_arbiter.sv
// Two-requester (fetch/data) arbiter for a single synchronous-read memory port.
// Optional round-robin tie-break enabled by defining SCIC_ARB_RR_EN; default is data-over-fetch priority.
module scic_mem_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_ack,
    output logic [DATA_W-1:0] f_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic [1:0]        gnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [1:0] GNT_NONE  = 2'b00;
    localparam logic [1:0] GNT_FETCH = 2'b01;
    localparam logic [1:0] GNT_DATA  = 2'b10;

    state_t              state_q, state_d;
    logic [1:0]          gnt_q, gnt_d;
    logic                wr_q, wr_d;
    logic                busy_q, busy_d;
    logic                mem_en_q, mem_en_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                f_ack_q, f_ack_d;
    logic                d_ack_q, d_ack_d;
    logic [DATA_W-1:0]   f_rdata_q, f_rdata_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
    logic                pick_data_s;
`ifdef SCIC_ARB_RR_EN
    logic                last_q, last_d;   // 1: data was granted last, 0: fetch
`endif

    // Winner selection when at least one requester is active in IDLE
    always_comb begin
`ifdef SCIC_ARB_RR_EN
        pick_data_s = d_req && (!f_req || !last_q);
`else
        pick_data_s = d_req;
`endif
    end

    // Next-state and next-output computation for the transaction FSM
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        wr_d        = wr_q;
        busy_d      = busy_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        f_ack_d     = 1'b0;
        d_ack_d     = 1'b0;
        f_rdata_d   = f_rdata_q;
        d_rdata_d   = d_rdata_q;
`ifdef SCIC_ARB_RR_EN
        last_d      = last_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (f_req || d_req) begin
                    state_d  = S_ISSUE;
                    busy_d   = 1'b1;
                    mem_en_d = 1'b1;
                    if (pick_data_s) begin
                        gnt_d       = GNT_DATA;
                        wr_d        = d_we;
                        mem_we_d    = d_we;
                        mem_addr_d  = d_addr;
                        mem_wdata_d = d_wdata;
                    end else begin
                        gnt_d      = GNT_FETCH;
                        wr_d       = 1'b0;
                        mem_addr_d = f_addr;
                    end
`ifdef SCIC_ARB_RR_EN
                    last_d = pick_data_s;
`endif
                end else begin
                    state_d = S_IDLE;
                    gnt_d   = GNT_NONE;
                    busy_d  = 1'b0;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // Read data is valid now; capture it so it appears together with the ack
                state_d = S_DONE;
                if (gnt_q == GNT_DATA) begin
                    d_ack_d = 1'b1;
                    if (!wr_q) begin
                        d_rdata_d = mem_rdata;
                    end else begin
                        d_rdata_d = d_rdata_q;
                    end
                end else begin
                    f_ack_d   = 1'b1;
                    f_rdata_d = mem_rdata;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                gnt_d   = GNT_NONE;
                busy_d  = 1'b0;
                wr_d    = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = GNT_NONE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            gnt_q       <= GNT_NONE;
            wr_q        <= 1'b0;
            busy_q      <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= {ADDR_W{1'b0}};
            mem_wdata_q <= {DATA_W{1'b0}};
            f_ack_q     <= 1'b0;
            d_ack_q     <= 1'b0;
            f_rdata_q   <= {DATA_W{1'b0}};
            d_rdata_q   <= {DATA_W{1'b0}};
`ifdef SCIC_ARB_RR_EN
            last_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            wr_q        <= wr_d;
            busy_q      <= busy_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            f_ack_q     <= f_ack_d;
            d_ack_q     <= d_ack_d;
            f_rdata_q   <= f_rdata_d;
            d_rdata_q   <= d_rdata_d;
`ifdef SCIC_ARB_RR_EN
            last_q      <= last_d;
`endif
        end
    end

    assign f_ack     = f_ack_q;
    assign d_ack     = d_ack_q;
    assign f_rdata   = f_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;
    assign gnt       = gnt_q;

endmodule

// File: tb/tb_scic_mem_arbiter.sv
// Self-checking bench for scic_mem_arbiter with a behavioural memory and arbitration model.
module tb_scic_mem_arbiter;

`ifdef SCIC_ARB_RR_EN
    localparam bit RR_BUILD = 1'b1;
`else
    localparam bit RR_BUILD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        f_req = 1'b0;
    logic [15:0] f_addr = 16'h0;
    logic        f_ack;
    logic [31:0] f_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [15:0] d_addr = 16'h0;
    logic [31:0] d_wdata = 32'h0;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        busy;
    logic [1:0]  gnt;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    scic_mem_arbiter #(.ADDR_W(16), .DATA_W(32)) dut (
        .clock(clk), .reset(reset),
        .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_rdata(f_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy), .gnt(gnt)
    );

    // Synchronous-read memory device with a preload port
    logic [31:0] dev_mem [0:63];
    logic        pre_we = 1'b0;
    logic [5:0]  pre_addr = 6'd0;
    logic [31:0] pre_data = 32'h0;
    always @(posedge clk) begin
        if (pre_we) begin
            dev_mem[pre_addr] <= pre_data;
        end else if (mem_en) begin
            if (mem_we) dev_mem[mem_addr[5:0]] <= mem_wdata;
            mem_rdata <= dev_mem[mem_addr[5:0]];
        end
    end

    // Bus monitor counting strobes and acks
    int          en_cnt = 0, we_cnt = 0, fack_cnt = 0, dack_cnt = 0, both_cnt = 0, bad_en_cnt = 0;
    logic [15:0] en_addr = 16'h0;
    logic        en_we = 1'b0;
    logic [1:0]  en_gnt = 2'b00;
    always @(posedge clk) begin
        if (mem_en === 1'b1) begin
            en_cnt  <= en_cnt + 1;
            en_addr <= mem_addr;
            en_we   <= mem_we;
            en_gnt  <= gnt;
            if (gnt == 2'b00) bad_en_cnt <= bad_en_cnt + 1;
        end
        if (mem_we === 1'b1) we_cnt <= we_cnt + 1;
        if (f_ack === 1'b1) fack_cnt <= fack_cnt + 1;
        if (d_ack === 1'b1) dack_cnt <= dack_cnt + 1;
        if (f_ack === 1'b1 && d_ack === 1'b1) both_cnt <= both_cnt + 1;
    end

    logic [31:0] ref_mem [0:63];
    bit          model_last_data = 1'b0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        f_req = 1'b0;
        d_req = 1'b0;
        step();
        step();
        reset = 1'b0;
        model_last_data = 1'b0;
    endtask

    task automatic poke(input logic [5:0] a, input logic [31:0] v);
        pre_we = 1'b1; pre_addr = a; pre_data = v;
        ref_mem[a] = v;
        step();
        pre_we = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 10 && busy !== 1'b0; i++) step();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL wait_idle: busy=%b required 0", busy);
        end
    endtask

    task automatic do_txn(input bit is_d, input bit we, input logic [15:0] addr,
                          input logic [31:0] wd, output int lat);
        wait_idle();
        if (is_d) begin
            d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wd;
        end else begin
            f_req = 1'b1; f_addr = addr;
        end
        lat = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            lat++;
            if (is_d ? d_ack : f_ack) break;
        end
        f_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    endtask

    task automatic test_reset();
        f_req = 1'b1; d_req = 1'b1;
        apply_reset();
        checks++;
        if ({f_ack, d_ack, mem_en, mem_we, busy, gnt} !== 7'b0) begin
            failures++;
            $display("FAIL reset_ctrl: got %b required 0000000", {f_ack, d_ack, mem_en, mem_we, busy, gnt});
        end
        checks++;
        if ({mem_addr, mem_wdata, f_rdata, d_rdata} !== 112'b0) begin
            failures++;
            $display("FAIL reset_data: addr=%h wdata=%h f_rdata=%h d_rdata=%h required all 0",
                     mem_addr, mem_wdata, f_rdata, d_rdata);
        end
        for (int i = 0; i < 64; i++) poke(i[5:0], $urandom);
    endtask

    task automatic test_fetch_read();
        int lat, e0;
        poke(6'h10, 32'hDEADBEEF);
        e0 = en_cnt;
        do_txn(1'b0, 1'b0, 16'h0010, 32'h0, lat);
        checks++;
        if (lat !== 3) begin failures++; $display("FAIL fetch_latency: got %0d required 3", lat); end
        checks++;
        if (f_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL fetch_rdata: got %h required deadbeef", f_rdata); end
        checks++;
        if (en_cnt - e0 !== 1) begin failures++; $display("FAIL fetch_en_count: got %0d required 1", en_cnt - e0); end
        checks++;
        if ({en_addr, en_we, en_gnt} !== {16'h0010, 1'b0, 2'b01}) begin
            failures++;
            $display("FAIL fetch_issue: addr=%h we=%b gnt=%b required 0010/0/01", en_addr, en_we, en_gnt);
        end
    endtask

    task automatic test_write_read();
        int lat, w0;
        logic [31:0] old;
        old = d_rdata;
        w0 = we_cnt;
        do_txn(1'b1, 1'b1, 16'h0020, 32'h12345678, lat);
        ref_mem[6'h20] = 32'h12345678;
        checks++;
        if (lat !== 3 || we_cnt - w0 !== 1) begin
            failures++;
            $display("FAIL write_ack: latency=%0d we_pulses=%0d required 3/1", lat, we_cnt - w0);
        end
        checks++;
        if ({en_addr, en_gnt, d_rdata} !== {16'h0020, 2'b10, old}) begin
            failures++;
            $display("FAIL write_side: addr=%h gnt=%b d_rdata=%h required 0020/10/%h", en_addr, en_gnt, d_rdata, old);
        end
        do_txn(1'b1, 1'b0, 16'h0020, 32'h0, lat);
        checks++;
        if (lat !== 3 || d_rdata !== 32'h12345678 || we_cnt - w0 !== 1) begin
            failures++;
            $display("FAIL read_back: latency=%0d d_rdata=%h required 3/12345678", lat, d_rdata);
        end
    endtask

    task automatic test_random();
        int lat;
        bit is_d, we;
        logic [5:0] a;
        logic [31:0] wd, exp_v;
        for (int n = 0; n < 24; n++) begin
            is_d = 1'($urandom_range(1, 0));
            we   = is_d & 1'($urandom_range(1, 0));
            a    = 6'($urandom_range(63, 0));
            wd   = $urandom;
            exp_v = we ? d_rdata : ref_mem[a];
            do_txn(is_d, we, {10'd0, a}, wd, lat);
            if (we) ref_mem[a] = wd;
            checks++;
            if (lat !== 3 || (is_d ? d_rdata : f_rdata) !== exp_v) begin
                failures++;
                $display("FAIL random_txn%0d: d=%b we=%b addr=%h latency=%0d data=%h required 3/%h",
                         n, is_d, we, a, lat, is_d ? d_rdata : f_rdata, exp_v);
            end
        end
    endtask

    task automatic test_tie();
        int t, t_d, t_f;
        bit first_d;
        apply_reset();
        for (int r = 0; r < 2; r++) begin
            wait_idle();
            first_d = !RR_BUILD || !model_last_data;
            f_addr = 16'h0003; d_addr = 16'h0004; d_we = 1'b0;
            f_req = 1'b1; d_req = 1'b1;
            t = 0; t_d = -1; t_f = -1;
            while (t < 16 && (t_d < 0 || t_f < 0)) begin
                step();
                t++;
                if (d_ack && t_d < 0) begin t_d = t; d_req = 1'b0; end
                if (f_ack && t_f < 0) begin t_f = t; f_req = 1'b0; end
            end
            f_req = 1'b0; d_req = 1'b0;
            model_last_data = !first_d;
            checks++;
            if (t_d !== (first_d ? 3 : 7) || t_f !== (first_d ? 7 : 3)) begin
                failures++;
                $display("FAIL tie_round%0d: d_ack at %0d f_ack at %0d required %0d/%0d",
                         r, t_d, t_f, first_d ? 3 : 7, first_d ? 7 : 3);
            end
            checks++;
            if (f_rdata !== ref_mem[3] || d_rdata !== ref_mem[4]) begin
                failures++;
                $display("FAIL tie_data%0d: f=%h d=%h required %h/%h", r, f_rdata, d_rdata, ref_mem[3], ref_mem[4]);
            end
        end
    endtask

    task automatic test_continuous();
        bit got[$];
        bit expq[$];
        bit w;
        int nf;
        apply_reset();
        for (int k = 0; k < 5; k++) begin
            w = !RR_BUILD || !model_last_data;
            expq.push_back(w);
            model_last_data = w;
        end
        f_addr = 16'h0001; d_addr = 16'h0002; d_we = 1'b0;
        f_req = 1'b1; d_req = 1'b1;
        for (int c = 0; c < 20; c++) begin
            step();
            if (d_ack) got.push_back(1'b1);
            if (f_ack) got.push_back(1'b0);
        end
        f_req = 1'b0; d_req = 1'b0;
        wait_idle();
        nf = 0;
        foreach (got[i]) if (!got[i]) nf++;
        checks++;
        if (got.size() !== expq.size()) begin
            failures++;
            $display("FAIL cont_count: got %0d acks required %0d", got.size(), expq.size());
        end
        checks++;
        if (got != expq) begin
            failures++;
            $display("FAIL cont_order: got %p required %p (1=data)", got, expq);
        end
        checks++;
        if (RR_BUILD ? (nf < 2 || nf > 3) : (nf != 0)) begin
            failures++;
            $display("FAIL cont_fetches: got %0d fetch acks", nf);
        end
    endtask

    task automatic test_reset_in_wait();
        int fa, lat;
        wait_idle();
        f_addr = 16'h0005; f_req = 1'b1;
        step();
        step();
        checks++;
        if ({busy, gnt} !== 3'b101) begin failures++; $display("FAIL rst_pre: busy/gnt=%b required 101", {busy, gnt}); end
        reset = 1'b1; f_req = 1'b0;
        fa = fack_cnt;
        step();
        checks++;
        if ({busy, gnt, mem_en, f_ack, d_ack} !== 5'b0) begin
            failures++;
            $display("FAIL rst_wait: busy/gnt/en/fack/dack=%b required 00000", {busy, gnt, mem_en, f_ack, d_ack});
        end
        reset = 1'b0;
        model_last_data = 1'b0;
        for (int i = 0; i < 4; i++) step();
        checks++;
        if (fack_cnt - fa !== 0) begin failures++; $display("FAIL rst_no_ack: got %0d acks required 0", fack_cnt - fa); end
        do_txn(1'b0, 1'b0, 16'h0005, 32'h0, lat);
        checks++;
        if (lat !== 3 || f_rdata !== ref_mem[5]) begin
            failures++;
            $display("FAIL rst_after: latency=%0d f_rdata=%h required 3/%h", lat, f_rdata, ref_mem[5]);
        end
    endtask

    task automatic test_drop_in_issue();
        int e0, fa;
        wait_idle();
        e0 = en_cnt; fa = fack_cnt;
        f_addr = 16'h0007; f_req = 1'b1;
        step();
        f_req = 1'b0; f_addr = 16'h0009;
        for (int i = 0; i < 8; i++) step();
        checks++;
        if (fack_cnt - fa !== 1 || en_cnt - e0 !== 1) begin
            failures++;
            $display("FAIL drop_issue: acks=%0d strobes=%0d required 1/1", fack_cnt - fa, en_cnt - e0);
        end
        checks++;
        if (f_rdata !== ref_mem[7] || en_addr !== 16'h0007) begin
            failures++;
            $display("FAIL drop_data: f_rdata=%h addr=%h required %h/0007", f_rdata, en_addr, ref_mem[7]);
        end
    endtask

    task automatic test_invariants();
        checks++;
        if (both_cnt !== 0 || bad_en_cnt !== 0) begin
            failures++;
            $display("FAIL invariants: dual_ack=%0d stray_en=%0d required 0/0", both_cnt, bad_en_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_fetch_read();
        test_write_read();
        test_random();
        test_tie();
        test_continuous();
        test_reset_in_wait();
        test_drop_in_issue();
        test_invariants();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
